// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// AXI4-Stream to UART transmitter. One DATA_WIDTH word is accepted per
// handshake and sent LSB first as: start bit, data bits, optional parity bit,
// then one or two stop bits. The bit period is max(prescale,1)*8 clk cycles,
// the same prescale meaning used by the matching UART receiver.
//
// Handshake: a word is consumed on a rising clk edge where
// s_axis_tvalid && s_axis_tready. The source must not wait for tready before
// raising tvalid. While tready is low nothing is consumed and no state changes.
// tready is registered: it is high only in IDLE, drops on the accept edge and
// returns on the edge that ends the last stop bit.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous, active-high reset
//   s_axis_tdata   in   word to transmit
//   s_axis_tvalid  in   word valid
//   s_axis_tready  out  word can be accepted (registered)
//   txd            out  serial line, idle high (registered)
//   busy           out  frame in progress (registered)
//   parity_mode    in   0/3 none, 1 even, 2 odd; latched at accept
//   two_stop       in   1 = two stop bits; latched at accept
//   prescale       in   bit period = max(prescale,1)*8 clk; latched at accept
//   state_dbg      out  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic [15:0]           prescale,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  txd_q, txd_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic                  two_stop_q, two_stop_d;
    logic [18:0]           reload_q, reload_d;
    logic [18:0]           timer_q, timer_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;

    logic [15:0]           presc_eff;
    logic [18:0]           reload_in;
    logic                  timer_done;
    logic                  last_data_bit;

    // max(prescale,1)*8 - 1 written as {max(prescale,1)-1, 3'b111}
    assign presc_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
    assign reload_in     = {presc_eff - 16'd1, 3'b111};
    assign timer_done    = (timer_q == 19'd0);
    assign last_data_bit = (bit_cnt_q == 4'(DATA_WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        tready_d   = tready_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        reload_d   = reload_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        // Every non-idle state counts the bit period down; bit ends at zero.
        if (state_q != ST_IDLE) begin
            timer_d = timer_done ? reload_q : timer_q - 19'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // Also raises tready on the first edge after reset release.
                tready_d = 1'b1;
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                if (s_axis_tvalid && tready_q) begin
                    shift_d    = s_axis_tdata;
                    // Parity is computed once from the accepted word.
                    par_bit_d  = (parity_mode == 2'd2) ? ~^s_axis_tdata : ^s_axis_tdata;
                    par_en_d   = (parity_mode == 2'd1) || (parity_mode == 2'd2);
                    two_stop_d = two_stop;
                    reload_d   = reload_in;
                    timer_d    = reload_in;
                    txd_d      = 1'b0;
                    tready_d   = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (timer_done) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = 4'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_done) begin
                    if (last_data_bit) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            txd_d   = par_bit_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        // shift_q[0] is on the line now; bit 1 is next.
                        txd_d     = shift_q[1];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (timer_done) begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer_done) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        // Next handshake may land on the very first IDLE cycle.
                        tready_d = 1'b1;
                        busy_d   = 1'b0;
                        txd_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_d    = 1'b1;
                tready_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            txd_q      <= 1'b1;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            reload_q   <= '0;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            reload_q   <= reload_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Directed test of uart_tx_framer. The driver pushes {prescale, two_stop,
// parity_mode, data} for each word it offers; a line monitor decodes txd,
// pops that entry when a start bit appears and checks every bit period level
// by level, the decoded word, the idle cycle after the stop bits and, when
// enabled, the inter-frame gap. The main process checks handshake latency,
// frame length in clk, reset behaviour and busy/tready levels.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

    localparam int DW = 8;

    // clock / reset
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s_axis_tdata  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          txd;
    logic          busy;
    logic [1:0]    parity_mode   = 2'd0;
    logic          two_stop      = 1'b0;
    logic [15:0]   prescale      = 16'd1;
    logic [2:0]    state_dbg;

    uart_tx_framer #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .prescale      (prescale),
        .state_dbg     (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // scoreboard: {prescale[15:0], two_stop, parity_mode[1:0], data[7:0]}
    logic [26:0] exp_q[$];

    // handshake counter
    int hs_cnt = 0;
    always @(posedge clk) begin
        if (!rst && s_axis_tvalid && s_axis_tready) hs_cnt++;
    end

    // line monitor
    logic          mon_active = 1'b0;
    int            mon_c, mon_period, mon_nbits, mon_idx, mon_b, mon_pos;
    logic [12:0]   mon_bits;
    logic [DW-1:0] mon_word, mon_data;
    logic [26:0]   mon_ent;
    logic          seen0, seen1;
    int            gap_cnt = 0;
    logic          check_gap = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            gap_cnt    = 0;
        end else begin
            if (!mon_active) begin
                if (txd === 1'b0) begin
                    if (check_gap) check("gap_clk", gap_cnt, 1);
                    check("frame_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) mon_ent = exp_q.pop_front();
                    else mon_ent = '0;
                    mon_data   = mon_ent[7:0];
                    mon_period = ((mon_ent[26:11] == 16'd0) ? 1 : int'(mon_ent[26:11])) * 8;
                    mon_bits   = '1;
                    mon_bits[0] = 1'b0;
                    for (int i = 0; i < DW; i++) mon_bits[1+i] = mon_data[i];
                    mon_idx = 1 + DW;
                    if (mon_ent[9:8] == 2'd1) begin
                        mon_bits[mon_idx] = ^mon_data;
                        mon_idx++;
                    end else if (mon_ent[9:8] == 2'd2) begin
                        mon_bits[mon_idx] = ~^mon_data;
                        mon_idx++;
                    end
                    mon_nbits  = mon_idx + (mon_ent[10] ? 2 : 1);
                    mon_c      = 0;
                    mon_word   = '0;
                    seen0      = 1'b0;
                    seen1      = 1'b0;
                    mon_active = 1'b1;
                end else begin
                    gap_cnt++;
                end
            end
            if (mon_active) begin
                mon_b   = mon_c / mon_period;
                mon_pos = mon_c % mon_period;
                if (mon_b < mon_nbits) begin
                    if (txd === 1'b1) seen1 = 1'b1;
                    else seen0 = 1'b1;
                    if (mon_pos == mon_period / 2 && mon_b >= 1 && mon_b <= DW)
                        mon_word[mon_b-1] = (txd === 1'b1);
                    if (mon_pos == mon_period - 1) begin
                        // {seen1,seen0}: 2'b10 = steady 1, 2'b01 = steady 0
                        check($sformatf("frame_bit%0d", mon_b), {30'd0, seen1, seen0},
                              mon_bits[mon_b] ? 32'd2 : 32'd1);
                        seen0 = 1'b0;
                        seen1 = 1'b0;
                    end
                end else begin
                    check("idle_after_stop", txd, 1);
                    check("rx_word", mon_word, mon_data);
                    mon_active = 1'b0;
                    gap_cnt    = 1;
                end
                mon_c++;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic ts, input logic [15:0] ps);
        int w = 0;
        while (s_axis_tready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("tready_before_send", s_axis_tready, 1);
        s_axis_tdata  = d;
        parity_mode   = pm;
        two_stop      = ts;
        prescale      = ps;
        s_axis_tvalid = 1'b1;
        exp_q.push_back({ps, ts, pm, d});
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        check("txd_low_after_accept", txd, 0);
        check("tready_low_after_accept", s_axis_tready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    // Called on the first negedge after the accept edge; returns clk count
    // until tready is back.
    task automatic wait_idle(input int exp_clk);
        int c = 0;
        while (s_axis_tready !== 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("frame_clk", c, exp_clk);
        check("busy_low_at_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  hs_base;
    logic line_quiet;

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_tready", s_axis_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_first_edge", s_axis_tready, 1);

        // T1: 8N1, prescale 1
        send(8'h55, 2'd0, 1'b0, 16'd1);
        wait_idle(80);

        // T2: prescale 2, even then odd parity
        send(8'h07, 2'd1, 1'b0, 16'd2);
        wait_idle(176);
        send(8'h07, 2'd2, 1'b0, 16'd2);
        wait_idle(176);

        // T3: two stop bits
        send(8'hA3, 2'd0, 1'b1, 16'd1);
        wait_idle(88);

        // T4: tvalid held high for three words
        hs_base       = hs_cnt;
        parity_mode   = 2'd0;
        two_stop      = 1'b0;
        prescale      = 16'd1;
        s_axis_tdata  = 8'h01;
        s_axis_tvalid = 1'b1;
        exp_q.push_back({16'd1, 1'b0, 2'd0, 8'h01});
        @(posedge clk);
        @(negedge clk);
        for (int i = 2; i <= 3; i++) begin
            s_axis_tdata = 8'(i);
            exp_q.push_back({16'd1, 1'b0, 2'd0, 8'(i)});
            @(negedge clk);
            check_gap = 1'b1;
            for (int w = 0; w < 2000 && s_axis_tready !== 1'b1; w++) @(negedge clk);
            check("b2b_tready", s_axis_tready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        wait_idle(80);
        check("b2b_handshakes", hs_cnt - hs_base, 3);
        check_gap = 1'b0;

        // T5: inputs changed mid-frame are ignored
        send(8'h5A, 2'd0, 1'b0, 16'd1);
        repeat (20) @(negedge clk);
        prescale     = 16'd4;
        parity_mode  = 2'd1;
        two_stop     = 1'b1;
        s_axis_tdata = 8'hFF;
        wait_idle(60);
        send(8'h5A, 2'd1, 1'b0, 16'd4);
        wait_idle(352);

        // prescale 0 behaves as 1
        send(8'h3C, 2'd0, 1'b0, 16'd0);
        wait_idle(80);

        // T6: reset during data bit 3 (clk 32..39 of the frame)
        send(8'hF0, 2'd0, 1'b0, 16'd1);
        repeat (34) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd, 1);
        check("midrst_busy", busy, 0);
        check("midrst_tready", s_axis_tready, 0);
        check("midrst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_midrst", s_axis_tready, 1);
        line_quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) line_quiet = 1'b0;
        end
        check("no_replay_after_rst", line_quiet, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
